btn_encode: RTL
===============

// Module: btn_encode
// PURPOSE
//  Front end that produces the 3-bit button code consumed by the mode decoder.
//  - Synchronises and debounces three raw pushbuttons.
//  - Emits a clean one-hot code: 001/010/100 for a single pressed button, 000 for idle or invalid.
//  - Strobes once per accepted press; flags multi-button chords as errors.
//  - Sits between the board pushbutton pins and the mode-select decoder.
// PARAMETERS
//  DEB_CYCLES  1000000  consecutive stable clocks before a debounced bit flips (10 ms @ 100 MHz); >= 2
//  CNT_W       20       debounce counter width; 2**CNT_W > DEB_CYCLES
// PORTS
//  clk        in   1  system clock, rising-edge
//  rst        in   1  reset; synchronous, active-high
//  btn_raw    in   3  raw pushbuttons, asynchronous, 1 = pressed
//  btn        out  3  one-hot code to decoder; 000 = none/invalid
//  press_stb  out  1  1-cycle pulse when a new valid code is loaded into btn
//  err        out  1  high while a multi-button chord is locked out
// BEHAVIOUR
//  Reset:
//  - rst is sampled on clk and clears all state: sync FFs, debounced bits, counters, FSM=IDLE.
//  - Outputs on reset: btn=000, press_stb=0, err=0.
//  - Reset asserted mid-press has priority: outputs are 0 on the next edge.
//  - A button held through reset release is re-debounced with full latency.
//  Synchroniser:
//  - Two flops per bit, reset to 0.
//  Debouncer, per bit, independent:
//  - Compare sync bit s[i] with debounced bit deb[i].
//  - s==deb: count <= 0.
//  - s!=deb and count==DEB_CYCLES-1: deb <= s, count <= 0.
//  - s!=deb otherwise: count <= count+1.
//  - Any mismatch gap shorter than DEB_CYCLES restarts the count, so no flip.
//  Latency:
//  - A raw change held stable appears on btn exactly DEB_CYCLES+3 clocks later.
//  - Breakdown: 2 synchroniser + DEB_CYCLES debounce + 1 registered FSM output.
//  - The same latency applies to press and release.
//  FSM (states IDLE, ACTIVE, LOCK); all outputs registered:
//  - IDLE: deb one-hot -> ACTIVE, btn<=deb, press_stb<=1.
//  - IDLE: deb has >=2 bits -> LOCK, err<=1.
//  - IDLE: deb==000 -> stay.
//  - ACTIVE: deb==btn -> stay, btn held, no further strobe.
//  - ACTIVE: deb==000 -> IDLE, btn<=000.
//  - ACTIVE: any other value (second button added, or direct swap) -> LOCK, btn<=000, err<=1.
//  - LOCK: stay, btn=000, err=1, until deb==000; then IDLE, err<=0, no strobe.
//  - press_stb is high for exactly one cycle per IDLE->ACTIVE transition.
//  Boundaries:
//  - Simultaneous press of two buttons goes to LOCK, never a transient code.
//  - Release of one button of a chord stays in LOCK.
//  - Counter never exceeds DEB_CYCLES-1, so no wrap.
// CONFIGURATION
//  BTN_LATCH_EN defined (sticky mode select):
//  - ACTIVE->IDLE on release keeps btn at the last code.
//  - In IDLE, a new valid press loads btn and pulses press_stb, even when it is the same code.
//  - Entering LOCK still clears btn to 000.
//  BTN_LATCH_EN undefined:
//  - btn follows the held button as described in BEHAVIOUR (momentary).
// TESTING  (bench uses DEB_CYCLES=4, so latency = 7 clocks)
//  1. Reset: rst=1 for 3 clks, btn_raw=000 -> btn=000, press_stb=0, err=0 during and after reset.
//  2. Clean press: btn_raw=001 held 20 clks -> btn=001 exactly 7 clks after the change,
//     press_stb=1 for 1 clk; release -> btn=000 exactly 7 clks later, no strobe.
//  3. Glitch: btn_raw=010 for 3 clks then 000 -> btn stays 000, press_stb never 1.
//  4. Chord: hold 001 until btn=001, then raise 100 -> after 7 clks btn=000, err=1;
//     drop 001 only -> err stays 1; drop all -> err=0 after 7 clks, no strobe.
//  5. Reset mid-press: btn=010 held, assert rst for 1 clk -> btn=000 next clk;
//     btn=010 again 7 clks after rst deasserts.
//  6. BTN_LATCH_EN: press/release 100 -> btn stays 100; press 001 -> btn=001 with one strobe;
//     chord 001+010 -> btn=000, err=1.

Source files
------------

// File: rtl/btn_encode_if.sv
// Pushbutton front-end bundle: raw pins in, one-hot code / strobe / chord error out.
// Latency: n/a (wiring only).
// Backpressure: none; the consumer samples btn/press_stb/err every cycle.
interface btn_encode_if;
    logic [2:0] btn_raw;
    logic [2:0] btn;
    logic       press_stb;
    logic       err;

    modport master (output btn_raw, input btn, press_stb, err);
    modport slave  (input btn_raw, output btn, press_stb, err);
endinterface

// File: rtl/btn_encode.sv
// Synchronise, debounce and one-hot encode three pushbuttons; BTN_LATCH_EN keeps the last code after release.
// Latency: DEB_CYCLES+3 clocks from a stable raw change to btn (2 sync + DEB_CYCLES debounce + 1 FSM).
// Backpressure: none; press_stb is a single-cycle pulse the decoder must catch.
module btn_encode #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 20
) (
    input  logic           clk,
    input  logic           rst,
    btn_encode_if.slave    bif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] LOCK   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [2:0]       sync_meta;
    logic [2:0]       sync_q;
    logic [2:0]       deb;
    logic [CNT_W-1:0] cnt [3];

    logic [1:0]       state;
    logic [2:0]       btn_q;
    logic             stb_q;
    logic             err_q;

    logic             deb_none;
    logic             deb_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= bif.btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // Any agreement between sync and debounced value restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_q[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_q[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        deb_none = (deb == 3'b000);
        deb_one  = !deb_none && ((deb & (deb - 3'd1)) == 3'b000);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            btn_q <= '0;
            stb_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            stb_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (deb_one) begin
                        state <= ACTIVE;
                        btn_q <= deb;
                        stb_q <= 1'b1;
                    end else if (!deb_none) begin
                        state <= LOCK;
                        btn_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (deb == btn_q) begin
                        state <= ACTIVE;
                    end else if (deb_none) begin
                        state <= IDLE;
`ifdef BTN_LATCH_EN
                        btn_q <= btn_q;
`else
                        btn_q <= '0;
`endif
                    end else begin
                        // Added button or direct swap: never pass a second code through.
                        state <= LOCK;
                        btn_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                LOCK: begin
                    btn_q <= '0;
                    if (deb_none) begin
                        state <= IDLE;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    btn_q <= '0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    assign bif.btn       = btn_q;
    assign bif.press_stb = stb_q;
    assign bif.err       = err_q;

endmodule
